inverse_shift_row_byte_sub: RTL and testbench
=============================================

INVERSE_SHIFT_ROW_BYTE_SUB -- requirements
Module: inverse_shift_row_byte_sub

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: ap_clk (rising edge) and ap_rst_n (sampled on ap_clk, 0 = reset).
REQ-002 ap_clk  in  1  system clock.
REQ-003 ap_rst_n  in  1  synchronous active-low reset.
REQ-004 ap_start  in  1  start request, level-sampled in IDLE.
REQ-005 ap_done  out  1  one-cycle pulse when write-back is complete.
REQ-006 ap_idle  out  1  high only in IDLE.
REQ-007 ap_ready  out  1  equal to ap_done.
REQ-008 statemt_address0, statemt_address1  out  5 each  state RAM port addresses.
REQ-009 statemt_ce0, statemt_ce1  out  1 each  port enables.
REQ-010 statemt_we0, statemt_we1  out  1 each  port write enables.
REQ-011 statemt_d0, statemt_d1  out  32 each  write data.
REQ-012 statemt_q0, statemt_q1  in  32 each  read data, valid one cycle after ce with we=0.

Function
REQ-013 The block SHALL apply AES InvShiftRows then InvSubBytes, in place, to statemt[0..15] (byte r+4c = row r, column c); entries 16..31 SHALL never be accessed.
REQ-014 Result: out[r+4c] = INV_SBOX[in[r+4*((c-r) mod 4)][7:0]]; bits [31:8] of read data SHALL be ignored, and written words SHALL be zero-extended 8-bit values.
REQ-015 FSM states: IDLE, READ, RWAIT, WRITE, DONE.
REQ-016 IDLE -> READ when ap_start=1; otherwise stay in IDLE.
REQ-017 READ: 8 cycles, counter k=0..7; each cycle ce0=ce1=1, we=0, address0=2k, address1=2k+1; q data SHALL be captured into a 16x8 buffer on the following cycle.
REQ-018 RWAIT: 1 cycle capturing the last pair, no RAM access.
REQ-019 WRITE: 8 cycles, k=0..7; each cycle ce=we=1 on both ports, address0=2k, address1=2k+1, data per REQ-014 (two S-box lookups per cycle).
REQ-020 DONE: 1 cycle, ap_done=ap_ready=1, no RAM access; then IDLE.
REQ-021 Latency: with ap_start sampled high at cycle T in IDLE, ap_done SHALL be high exactly at T+18; a new start is accepted no earlier than T+19.
REQ-022 ap_start SHALL be ignored outside IDLE; ap_start held high SHALL produce back-to-back runs with one IDLE cycle between them.
REQ-023 ce and we SHALL be 0 in IDLE, RWAIT and DONE.
REQ-024 ap_idle SHALL be 0 from T+1 through T+18.

Reset
REQ-025 With ap_rst_n=0 at a clock edge, the FSM SHALL go to IDLE, counters and buffer SHALL clear, ap_done=ap_ready=0, ap_idle=1, and all ce/we=0 from the next cycle.
REQ-026 A reset during READ or WRITE SHALL abort the run immediately: no further RAM writes, and no ap_done for the aborted run.

Structure
REQ-027 The shared package aes_dec_pkg SHALL hold the FSM state enum, STATE_BYTES=16, and the INV_SBOX 256x8 constant.
REQ-028 The 256x8 combinational ROM SHALL be sub-module aes_inv_sbox, instantiated twice.

Verification
REQ-029 All zeros: statemt[0..15]=0, start -> all 16 words = 0x52, ap_done at T+18.
REQ-030 Identity: statemt[i]=i -> out[0]=0x52, out[1]=INV_SBOX[13]=0xF3, out[5]=INV_SBOX[1]=0x09.
REQ-031 Upper-bit masking: statemt[0]=0x00000163 -> out[0]=0x00000000; statemt[0]=0xFFFFFFFF -> out[0]=0x7D.
REQ-032 Reset asserted at T+12 (mid-WRITE) -> ap_done never asserts; words with k>=2 remain unchanged; ap_idle=1 after reset.
REQ-033 ap_start held high -> ap_done at T+18 and T+37; addresses 16..31 never driven with ce=1.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption helpers: FSM encoding, state
// size and the inverse S-box table.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int STATE_BYTES = 16;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Source byte for destination r+4c after InvShiftRows: column (c-r) mod 4,
    // which 2-bit wrap-around subtraction gives for free.
    function automatic logic [3:0] src_index(input logic [3:0] dst);
        logic [1:0] r;
        logic [1:0] c;
        r = dst[1:0];
        c = dst[3:2];
        return {c - r, r};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    assign data_o = INV_SBOX[addr_i];

endmodule

// File: rtl/inverse_shift_row_byte_sub.sv
// In-place AES InvShiftRows + InvSubBytes over statemt[0..15]: read all 16
// bytes into a local buffer, then write back two transformed bytes per cycle.
module inverse_shift_row_byte_sub
    import aes_dec_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [4:0]  statemt_address0,
    output logic        statemt_ce0,
    output logic        statemt_we0,
    output logic [31:0] statemt_d0,
    input  logic [31:0] statemt_q0,
    output logic [4:0]  statemt_address1,
    output logic        statemt_ce1,
    output logic        statemt_we1,
    output logic [31:0] statemt_d1,
    input  logic [31:0] statemt_q1,
    output logic [2:0]  dbg_state_o
);

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic       cap_valid_q;
    logic [2:0] cap_k_q;
    logic [7:0] buf_q [STATE_BYTES];

    logic [7:0] sbox_in0, sbox_in1;
    logic [7:0] sbox_out0, sbox_out1;
    logic       access, writing;
    logic       unused_hi;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                k_d = 3'd0;
                if (ap_start) state_d = ST_READ;
            end
            ST_READ: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                k_d     = 3'd0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read data arrives one cycle after the request, so the capture index lags k.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            cap_valid_q <= 1'b0;
            cap_k_q     <= 3'd0;
            for (int i = 0; i < STATE_BYTES; i++) buf_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cap_valid_q <= (state_q == ST_READ);
            cap_k_q     <= k_q;
            if (cap_valid_q) begin
                buf_q[{cap_k_q, 1'b0}] <= statemt_q0[7:0];
                buf_q[{cap_k_q, 1'b1}] <= statemt_q1[7:0];
            end
        end
    end

    assign sbox_in0 = buf_q[src_index({k_q, 1'b0})];
    assign sbox_in1 = buf_q[src_index({k_q, 1'b1})];

    aes_inv_sbox u_sbox0 (.addr_i(sbox_in0), .data_o(sbox_out0));
    aes_inv_sbox u_sbox1 (.addr_i(sbox_in1), .data_o(sbox_out1));

    // Gating with the reset input stops RAM traffic in the very cycle reset is seen.
    assign access  = ap_rst_n && (state_q == ST_READ || state_q == ST_WRITE);
    assign writing = ap_rst_n && (state_q == ST_WRITE);

    assign statemt_ce0      = access;
    assign statemt_ce1      = access;
    assign statemt_we0      = writing;
    assign statemt_we1      = writing;
    assign statemt_address0 = {1'b0, k_q, 1'b0};
    assign statemt_address1 = {1'b0, k_q, 1'b1};
    assign statemt_d0       = {24'h000000, sbox_out0};
    assign statemt_d1       = {24'h000000, sbox_out1};

    assign ap_done     = (state_q == ST_DONE);
    assign ap_ready    = ap_done;
    assign ap_idle     = (state_q == ST_IDLE);
    assign dbg_state_o = state_q;

    assign unused_hi = ^{statemt_q0[31:8], statemt_q1[31:8]};

endmodule

// File: tb/tb_inverse_shift_row_byte_sub.sv
// Randomized bench for inverse_shift_row_byte_sub with a RAM model and a
// queue-based scoreboard fed from an independently derived inverse S-box.
module tb_inverse_shift_row_byte_sub;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  statemt_address0, statemt_address1;
    logic        statemt_ce0, statemt_ce1, statemt_we0, statemt_we1;
    logic [31:0] statemt_d0, statemt_d1;
    logic [31:0] statemt_q0, statemt_q1;
    logic [2:0]  dbg_state;

    always #5 ap_clk = ~ap_clk;

    inverse_shift_row_byte_sub dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .statemt_address0(statemt_address0), .statemt_ce0(statemt_ce0),
        .statemt_we0(statemt_we0), .statemt_d0(statemt_d0), .statemt_q0(statemt_q0),
        .statemt_address1(statemt_address1), .statemt_ce1(statemt_ce1),
        .statemt_we1(statemt_we1), .statemt_d1(statemt_d1), .statemt_q1(statemt_q1),
        .dbg_state_o(dbg_state)
    );

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // RAM model; the bench preloads words through the set_* port.
    logic [31:0] mem [32];
    logic        set_en = 1'b0;
    logic [4:0]  set_addr = 5'd0;
    logic [31:0] set_data = 32'd0;

    always @(posedge ap_clk) begin
        if (set_en) mem[set_addr] <= set_data;
        if (statemt_ce0) begin
            if (statemt_we0) mem[statemt_address0] <= statemt_d0;
            else statemt_q0 <= mem[statemt_address0];
        end
        if (statemt_ce1) begin
            if (statemt_we1) mem[statemt_address1] <= statemt_d1;
            else statemt_q1 <= mem[statemt_address1];
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    logic [36:0] exp_q [$];
    int done_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference inverse S-box derived from GF(2^8) inversion plus the affine map.
    logic [7:0] inv_tbl [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] hi, lo;
        hi = v << n;
        lo = v >> (8 - n);
        return hi | lo;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    logic [7:0] m_in [16];
    logic [7:0] m_out [16];

    // Each row r is rotated right by r columns, then every byte is substituted.
    task automatic model();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m_out[r + 4 * c] = inv_tbl[m_in[r + 4 * ((c - r + 4) % 4)]];
    endtask

    task automatic push_writes();
        logic [4:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 5'(i);
            exp_q.push_back({a, 24'h000000, m_out[i]});
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < 16; i++) m_in[i] = mem[i][7:0];
    endtask

    task automatic load(input int addr, input logic [31:0] val);
        set_addr = 5'(addr);
        set_data = val;
        set_en   = 1'b1;
        @(posedge ap_clk); #1;
        set_en = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < 32; i++) load(i, $urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge ap_clk); #1;
            if (done_q.size() == 0 && exp_q.size() == 0) break;
        end
        if (done_q.size() != 0 || exp_q.size() != 0) begin
            fail("timeout_waiting_for_run");
            done_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic start_run();
        check("idle_before_start", ap_idle, 1'b1);
        snapshot();
        model();
        push_writes();
        done_q.push_back(cyc + 18);
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        check("idle_low_in_run", ap_idle, 1'b0);
    endtask

    task automatic run_once();
        start_run();
        wait_drain();
    endtask

    // Monitor: compare every RAM write and every ap_done pulse against the queues.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (statemt_ce0) check("addr0_in_range", statemt_address0 < 5'd16, 1'b1);
            if (statemt_ce1) check("addr1_in_range", statemt_address1 < 5'd16, 1'b1);
            if (statemt_ce0 && statemt_we0) begin
                if (exp_q.size() == 0) fail("unexpected_write_port0");
                else check("write_port0", {statemt_address0, statemt_d0}, exp_q.pop_front());
            end
            if (statemt_ce1 && statemt_we1) begin
                if (exp_q.size() == 0) fail("unexpected_write_port1");
                else check("write_port1", {statemt_address1, statemt_d1}, exp_q.pop_front());
            end
            if (ap_done) begin
                check("ready_equals_done", ap_ready, 1'b1);
                if (done_q.size() == 0) fail("unexpected_ap_done");
                else check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    logic [31:0] pre [16];
    int c0;

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        for (int a = 0; a < 256; a++) inv_tbl[fwd_sbox(8'(a))] = 8'(a);

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_idle", ap_idle, 1'b1);
        check("rst_done", ap_done, 1'b0);
        check("rst_ready", ap_ready, 1'b0);
        check("rst_ce_we", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1}, 4'b0000);
        ap_rst_n = 1'b1;
        load_random();

        // All-zero state
        for (int i = 0; i < 16; i++) load(i, 32'h0);
        run_once();
        check("zeros_out0", mem[0], 32'h52);
        check("zeros_out15", mem[15], 32'h52);

        // Identity pattern
        for (int i = 0; i < 16; i++) load(i, 32'(i));
        run_once();
        check("ident_out0", mem[0], 32'h52);
        check("ident_out1", mem[1], 32'hf3);
        check("ident_out5", mem[5], 32'h09);

        // Upper bits of read data must be ignored
        load(0, 32'h00000163);
        run_once();
        check("mask_163", mem[0], 32'h0);
        load(0, 32'hffffffff);
        run_once();
        check("mask_ffffffff", mem[0], 32'h7d);

        // Random states, random upper bits
        for (int t = 0; t < 6; t++) begin
            load_random();
            run_once();
        end

        // ap_start held high: back-to-back runs with one IDLE cycle between
        load_random();
        check("b2b_idle_before", ap_idle, 1'b1);
        c0 = cyc;
        snapshot();
        model();
        push_writes();
        for (int i = 0; i < 16; i++) m_in[i] = m_out[i];
        model();
        push_writes();
        done_q.push_back(c0 + 18);
        done_q.push_back(c0 + 37);
        ap_start = 1'b1;
        repeat (19) @(posedge ap_clk);
        #1;
        check("b2b_idle_gap", ap_idle, 1'b1);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        wait_drain();

        // Reset in the third WRITE cycle aborts the run
        load_random();
        for (int i = 0; i < 16; i++) pre[i] = mem[i];
        start_run();
        repeat (11) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        exp_q.delete();
        done_q.delete();
        check("abort_idle", ap_idle, 1'b1);
        check("abort_done", ap_done, 1'b0);
        check("abort_ce_we", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1}, 4'b0000);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        repeat (25) @(posedge ap_clk);
        #1;
        check("abort_idle_after", ap_idle, 1'b1);
        for (int i = 0; i < 4; i++) check("abort_written_word", mem[i], {24'h0, m_out[i]});
        for (int i = 4; i < 16; i++) check("abort_untouched_word", mem[i], pre[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
